// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON-p permutation core.
// The state struct keeps x0 in the most significant word so it maps directly onto the 320-bit bus.
package ascon_pkg;

    localparam int MAX_ROUNDS = 12;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } state_t;

    localparam logic [7:0] ROUND_CONST [0:MAX_ROUNDS-1] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    // Linear-layer rotate-right amounts, two per word
    localparam int unsigned ROT_X0_A = 19;
    localparam int unsigned ROT_X0_B = 28;
    localparam int unsigned ROT_X1_A = 61;
    localparam int unsigned ROT_X1_B = 39;
    localparam int unsigned ROT_X2_A = 1;
    localparam int unsigned ROT_X2_B = 6;
    localparam int unsigned ROT_X3_A = 10;
    localparam int unsigned ROT_X3_B = 17;
    localparam int unsigned ROT_X4_A = 7;
    localparam int unsigned ROT_X4_B = 41;

    function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, bitsliced S-box, linear diffusion.
module ascon_round
    import ascon_pkg::*;
(
    input  state_t     s_in,
    input  logic [7:0] rc,
    output state_t     s_out
);

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] c0, c1, c2, c3, c4;

    assign a0 = s_in.x0 ^ s_in.x4;
    assign a1 = s_in.x1;
    assign a2 = s_in.x2 ^ {56'h0, rc} ^ s_in.x1;
    assign a3 = s_in.x3;
    assign a4 = s_in.x4 ^ s_in.x3;

    // x_k ^= ~x_(k+1) & x_(k+2), all on pre-update values
    assign b0 = a0 ^ (~a1 & a2);
    assign b1 = a1 ^ (~a2 & a3);
    assign b2 = a2 ^ (~a3 & a4);
    assign b3 = a3 ^ (~a4 & a0);
    assign b4 = a4 ^ (~a0 & a1);

    assign c0 = b0 ^ b4;
    assign c1 = b1 ^ b0;
    assign c2 = ~b2;
    assign c3 = b3 ^ b2;
    assign c4 = b4;

    assign s_out.x0 = c0 ^ ror(c0, ROT_X0_A) ^ ror(c0, ROT_X0_B);
    assign s_out.x1 = c1 ^ ror(c1, ROT_X1_A) ^ ror(c1, ROT_X1_B);
    assign s_out.x2 = c2 ^ ror(c2, ROT_X2_A) ^ ror(c2, ROT_X2_B);
    assign s_out.x3 = c3 ^ ror(c3, ROT_X3_A) ^ ror(c3, ROT_X3_B);
    assign s_out.x4 = c4 ^ ror(c4, ROT_X4_A) ^ ror(c4, ROT_X4_B);

endmodule

// File: rtl/permutation.sv
// Iterative ASCON-p core: one round per clock, rounds index from 12-a up to 11.
// State | meaning: IDLE = waiting for start; RUN = applying rounds, busy high.
module permutation #(
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   rounds,
    input  logic [319:0] in,
    output logic [319:0] out,
    output logic         busy,
    output logic         done
);
    import ascon_pkg::*;

    typedef enum logic {IDLE, RUN} fsm_t;

    localparam logic [3:0] LAST_IDX = 4'(MAX_ROUNDS - 1);
    localparam logic [3:0] END_IDX  = 4'(MAX_ROUNDS);

    fsm_t       fsm;
    state_t     st;
    state_t     st_next;
    logic [3:0] idx;
    logic [3:0] a_clamped;
    logic [7:0] rc;

    assign a_clamped = (rounds > END_IDX) ? END_IDX : rounds;
    // idx == END_IDX only happens for a zero-round run; no constant is used then
    assign rc = (idx < END_IDX) ? ROUND_CONST[idx] : 8'h00;

    ascon_round u_round (
        .s_in  (st),
        .rc    (rc),
        .s_out (st_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm  <= IDLE;
            st   <= '0;
            idx  <= '0;
            out  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        st   <= state_t'(in);
                        idx  <= END_IDX - a_clamped;
                        busy <= 1'b1;
                        fsm  <= RUN;
                    end
                end
                RUN: begin
                    if (idx >= END_IDX) begin
                        out  <= st;
                        done <= 1'b1;
                        busy <= 1'b0;
                        fsm  <= IDLE;
                    end else begin
                        st  <= st_next;
                        idx <= idx + 4'd1;
                        if (idx == LAST_IDX) begin
                            out  <= st_next;
                            done <= 1'b1;
                            busy <= 1'b0;
                            fsm  <= IDLE;
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_permutation.sv
// Self-checking bench for permutation: directed and randomized runs against a table-driven ASCON-p model.
module tb_permutation;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   rounds;
    logic [319:0] in_s;
    logic [319:0] out_s;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    permutation dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .rounds (rounds),
        .in     (in_s),
        .out    (out_s),
        .busy   (busy),
        .done   (done)
    );

    // Reference tables: ASCON 5-bit S-box (x0 is the MSB of a column), round constants, rotations
    logic [4:0] sbox [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    logic [7:0] rct [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                             8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
    int rot [5][2] = '{'{19, 28}, '{61, 39}, '{1, 6}, '{10, 17}, '{7, 41}};

    localparam logic [319:0] VEC_IN = 320'h80400c0600000000_c82cbe1c72be1a3a_85621d92797f8475_23fd6519897d9e12_5c0609b2f5ca3aaa;
    localparam logic [319:0] ZERO_P1 = 320'h000964b00000004b_0000000096000213_53ffffffffffff90_12e580000000004b_0000000000000000;

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] model(input logic [319:0] s, input int r);
        logic [63:0]  x [5];
        logic [63:0]  y [5];
        logic [4:0]   col;
        logic [4:0]   v;
        logic [319:0] res;
        int a;
        a = (r > 12) ? 12 : r;
        for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
        for (int i = 12 - a; i < 12; i++) begin
            x[2] = x[2] ^ {56'h0, rct[i]};
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                v = sbox[col];
                for (int w = 0; w < 5; w++) y[w][b] = v[4 - w];
            end
            for (int w = 0; w < 5; w++)
                x[w] = y[w] ^ rr(y[w], rot[w][0]) ^ rr(y[w], rot[w][1]);
        end
        for (int w = 0; w < 5; w++) res[319 - 64*w -: 64] = x[w];
        return res;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int k = 0; k < 10; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One run; optional perturbation of start/rounds/in while busy
    task automatic run(input logic [319:0] s, input logic [3:0] r, input bit perturb, input string tag);
        logic [319:0] prev;
        logic [319:0] exp;
        int lat;
        int exp_lat;
        prev = out_s;
        exp  = model(s, int'(r));
        exp_lat = (r == 0) ? 1 : ((r > 12) ? 12 : int'(r));
        @(negedge clk);
        in_s = s; rounds = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy_after_start"}, 320'(busy), 320'(1));
        lat = 0;
        while (!done && lat < 40) begin
            check({tag, " out_stable"}, out_s, prev);
            if (perturb) begin
                start  = 1'($urandom_range(0, 1));
                rounds = 4'($urandom);
                in_s   = rand320();
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, " done_seen"}, 320'(done), 320'(1));
        check({tag, " latency"}, 320'(lat), 320'(exp_lat));
        check({tag, " out"}, out_s, exp);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 320'(done), 320'(0));
        check({tag, " idle_after"}, 320'(busy), 320'(0));
        check({tag, " out_hold"}, out_s, exp);
    endtask

    initial begin
        logic [319:0] exp12;
        logic [319:0] prev;
        logic [319:0] s;
        logic [3:0]   r;
        rst = 1'b1; start = 1'b0; rounds = 4'd0; in_s = '0;
        #12;
        check("reset_out", out_s, 320'(0));
        check("reset_busy", 320'(busy), 320'(0));
        check("reset_done", 320'(done), 320'(0));
        @(negedge clk); rst = 1'b0;

        run(320'(0), 4'd1, 1'b0, "zero_p1");
        check("zero_p1_golden", out_s, ZERO_P1);

        run(VEC_IN, 4'd12, 1'b0, "vec_p12");
        run(VEC_IN, 4'd6, 1'b0, "vec_p6");
        run(VEC_IN, 4'd8, 1'b0, "vec_p8");
        run(VEC_IN, 4'd13, 1'b1, "vec_p13_perturb");
        run(VEC_IN, 4'd12, 1'b1, "vec_p12_perturb");
        run(VEC_IN, 4'd0, 1'b0, "vec_p0");
        check("p0_identity", out_s, VEC_IN);

        // back-to-back with start held high: done at 12, 25, 38 after the load edge
        exp12 = model(VEC_IN, 12);
        run(320'(0), 4'd0, 1'b0, "pre_b2b");
        prev = out_s;
        @(negedge clk);
        in_s = VEC_IN; rounds = 4'd12; start = 1'b1;
        @(posedge clk); #1;
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_done_t%0d", t), 320'(done), 320'(t == 12 || t == 25 || t == 38));
            check($sformatf("b2b_out_t%0d", t), out_s, (t < 12) ? prev : exp12);
        end
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;

        for (int k = 0; k < 8; k++) begin
            s = rand320();
            r = 4'($urandom_range(0, 15));
            run(s, r, 1'($urandom_range(0, 1)), $sformatf("rand%0d_r%0d", k, r));
        end

        // asynchronous reset after three rounds of a 12-round run
        @(negedge clk);
        in_s = VEC_IN; rounds = 4'd12; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out", out_s, 320'(0));
        check("midrst_busy", 320'(busy), 320'(0));
        check("midrst_done", 320'(done), 320'(0));
        @(negedge clk); rst = 1'b0;
        for (int t = 0; t < 15; t++) begin
            @(posedge clk); #1;
            check($sformatf("postrst_done_t%0d", t), 320'(done), 320'(0));
            check($sformatf("postrst_busy_t%0d", t), 320'(busy), 320'(0));
        end

        run(VEC_IN, 4'd12, 1'b0, "after_reset_p12");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
